// File: rtl/eta16_key_operand_feeder_if.sv
// Operand/result bus between the key-locked adder feeder and its neighbours.
//   slave  : the feeder side (accepts operand pairs, drives the adder, returns results)
//   master : the environment side (offers pairs, models the adder, consumes results)
// Signals:
//   in_valid_i/in_ready_o     operand pair handshake
//   a1_i/a2_i                 operand pair
//   add1_o/add2_o/keyinput_o  drive the combinational locked adder
//   result_i                  adder result (DATA_WIDTH+1 bits)
//   res_o/res_valid_o/res_ready_i  captured result handshake
interface eta16_key_operand_feeder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int KEY_WIDTH  = 32
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DATA_WIDTH-1:0] a1_i;
  logic [DATA_WIDTH-1:0] a2_i;
  logic [DATA_WIDTH-1:0] add1_o;
  logic [DATA_WIDTH-1:0] add2_o;
  logic [KEY_WIDTH-1:0]  keyinput_o;
  logic [DATA_WIDTH:0]   result_i;
  logic [DATA_WIDTH:0]   res_o;
  logic                  res_valid_o;
  logic                  res_ready_i;

  modport slave (
    input  in_valid_i, a1_i, a2_i, result_i, res_ready_i,
    output in_ready_o, add1_o, add2_o, keyinput_o, res_o, res_valid_o
  );

  modport master (
    output in_valid_i, a1_i, a2_i, result_i, res_ready_i,
    input  in_ready_o, add1_o, add2_o, keyinput_o, res_o, res_valid_o
  );
endinterface

// File: rtl/eta16_key_operand_feeder.sv
// Feeder and result-capture stage for the 32-bit-key locked 16-bit
// error-tolerant type-2 adder.
//   - The key is shifted in serially (MSB first, then one even-parity bit)
//     into a shadow register and only applied to keyinput_o after the parity
//     of all KEY_WIDTH+1 bits checks out.
//   - Operand pairs are registered into the adder (Stage A) through a
//     valid/ready handshake; the adder result is captured one cycle later
//     (Stage B).
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   key_load_start_i         request a (re)key
//   key_bit_i/_valid_i       serial key bit stream
//   bus (slave modport)      operand/adder/result bus, see the interface
//   armed_o                  key applied, operands accepted
//   fault_o                  last key load failed parity
//   fault_count_o            saturating count of parity failures
module eta16_key_operand_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int KEY_WIDTH  = 32,
  parameter int FCNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_load_start_i,
  input  logic                   key_bit_i,
  input  logic                   key_bit_valid_i,
  eta16_key_operand_feeder_if.slave bus,
  output logic                   armed_o,
  output logic                   fault_o,
  output logic [FCNT_WIDTH-1:0]  fault_count_o
);

  localparam int CW = $clog2(KEY_WIDTH + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_ARMED,
    S_FAULT
  } state_t;

  state_t                state_q;
  logic [KEY_WIDTH:0]    shadow_q;
  logic [CW-1:0]         cnt_q;
  logic [KEY_WIDTH-1:0]  keyinput_q;
  logic                  armed_q;
  logic                  fault_q;
  logic                  pending_q;
  logic [FCNT_WIDTH-1:0] fcnt_q;

  logic                  a_valid_q, a_valid_d;
  logic [DATA_WIDTH-1:0] add1_q, add1_d;
  logic [DATA_WIDTH-1:0] add2_q, add2_d;
  logic                  res_valid_q, res_valid_d;
  logic [DATA_WIDTH:0]   res_q, res_d;

  logic accept;
  logic adv_b;
  logic in_ready;
  logic pipe_empty;

  // Key FSM: all outputs are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shadow_q   <= '0;
      cnt_q      <= '0;
      keyinput_q <= '0;
      armed_q    <= 1'b0;
      fault_q    <= 1'b0;
      pending_q  <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (key_load_start_i) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
          end
        end

        S_LOAD: begin
          // A restart wins over a bit arriving in the same cycle.
          if (key_load_start_i) begin
            cnt_q <= '0;
          end else if (key_bit_valid_i) begin
            shadow_q <= {shadow_q[KEY_WIDTH-1:0], key_bit_i};
            cnt_q    <= cnt_q + CW'(1);
            if (cnt_q == CW'(KEY_WIDTH)) begin
              state_q <= S_CHECK;
            end
          end
        end

        S_CHECK: begin
          if (^shadow_q == 1'b0) begin
            state_q    <= S_ARMED;
            keyinput_q <= shadow_q[KEY_WIDTH:1];
            armed_q    <= 1'b1;
          end else begin
            state_q <= S_FAULT;
            fault_q <= 1'b1;
            if (fcnt_q != '1) begin
              fcnt_q <= fcnt_q + FCNT_WIDTH'(1);
            end
          end
        end

        S_ARMED: begin
          // The rekey waits until both pipeline stages have drained so no
          // in-flight pair is computed under a cleared key.
          if (pending_q && pipe_empty) begin
            state_q    <= S_LOAD;
            pending_q  <= 1'b0;
            cnt_q      <= '0;
            keyinput_q <= '0;
            armed_q    <= 1'b0;
          end else if (key_load_start_i) begin
            pending_q <= 1'b1;
          end
        end

        S_FAULT: begin
          keyinput_q <= '0;
          if (key_load_start_i) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            fault_q <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign pipe_empty = !a_valid_q && !res_valid_q;
  assign adv_b      = a_valid_q && (!res_valid_q || bus.res_ready_i);
  assign in_ready   = armed_q && !pending_q && (!a_valid_q || adv_b);
  assign accept     = bus.in_valid_i && in_ready;

  always_comb begin
    a_valid_d   = a_valid_q;
    add1_d      = add1_q;
    add2_d      = add2_q;
    res_valid_d = res_valid_q;
    res_d       = res_q;

    if (accept) begin
      a_valid_d = 1'b1;
      add1_d    = bus.a1_i;
      add2_d    = bus.a2_i;
    end else if (adv_b) begin
      a_valid_d = 1'b0;
    end

    if (adv_b) begin
      res_valid_d = 1'b1;
      res_d       = bus.result_i;
    end else if (bus.res_ready_i) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_q   <= 1'b0;
      add1_q      <= '0;
      add2_q      <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      a_valid_q   <= a_valid_d;
      add1_q      <= add1_d;
      add2_q      <= add2_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.add1_o      = add1_q;
  assign bus.add2_o      = add2_q;
  assign bus.keyinput_o  = keyinput_q;
  assign bus.res_o       = res_q;
  assign bus.res_valid_o = res_valid_q;
  assign armed_o         = armed_q;
  assign fault_o         = fault_q;
  assign fault_count_o   = fcnt_q;

endmodule

// File: tb/tb_eta16_key_operand_feeder.sv
module tb_eta16_key_operand_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_load_start = 1'b0;
  logic       key_bit = 1'b0;
  logic       key_bit_valid = 1'b0;
  logic       armed;
  logic       fault;
  logic [3:0] fcnt;

  int vec_n  = 0;
  int miss_n = 0;
  int acc_n  = 0;
  logic [16:0] got_q[$];

  eta16_key_operand_feeder_if #(.DATA_WIDTH(16), .KEY_WIDTH(32)) bus();

  eta16_key_operand_feeder #(.DATA_WIDTH(16), .KEY_WIDTH(32), .FCNT_WIDTH(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .key_load_start_i (key_load_start),
    .key_bit_i        (key_bit),
    .key_bit_valid_i  (key_bit_valid),
    .bus              (bus),
    .armed_o          (armed),
    .fault_o          (fault),
    .fault_count_o    (fcnt)
  );

  // Stub adder: plain unsigned sum, key ignored.
  assign bus.result_i = {1'b0, bus.add1_o} + {1'b0, bus.add2_o};

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a1;
    logic [15:0] a2;
    logic [16:0] res;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_n++;
    if (act !== exp) begin
      miss_n++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1 with inputs already set; records handshakes seen
  // before the next edge, then returns at the following posedge+1.
  task automatic cyc();
    #1;
    if (bus.res_valid_o && bus.res_ready_i) got_q.push_back(bus.res_o);
    if (bus.in_valid_i && bus.in_ready_o) acc_n++;
    @(posedge clk);
    #1;
  endtask

  // Requests a load, waits until LOAD is entered, then shifts key+parity.
  // Returns with the FSM in CHECK.
  task automatic load_key(input logic [31:0] key, input logic par);
    logic [32:0] frame;
    int n;
    frame = {key, par};
    key_load_start = 1'b1;
    cyc();
    key_load_start = 1'b0;
    n = 0;
    while ((armed || fault) && n < 20) begin
      cyc();
      n++;
    end
    chk("load_entry_timeout", 64'(n < 20), 64'd1);
    for (int i = 32; i >= 0; i--) begin
      key_bit       = frame[i];
      key_bit_valid = 1'b1;
      cyc();
    end
    key_bit_valid = 1'b0;
  endtask

  task automatic set_pair(input logic [15:0] a1, input logic [15:0] a2);
    bus.a1_i = a1;
    bus.a2_i = a2;
    bus.in_valid_i = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t bp[3];
    int n;

    tbl[0] = '{16'h29AF, 16'h7A1B, 17'h0A3CA};
    tbl[1] = '{16'h1100, 16'h1111, 17'h02211};
    tbl[2] = '{16'h8943, 16'hFFFF, 17'h18942};
    tbl[3] = '{16'hFFFF, 16'h0001, 17'h10000};
    tbl[4] = '{16'hFFFF, 16'hFFFF, 17'h1FFFE};
    tbl[5] = '{16'h0000, 16'h0000, 17'h00000};

    bp[0] = '{16'h0001, 16'h0002, 17'h00003};
    bp[1] = '{16'h1234, 16'h4321, 17'h05555};
    bp[2] = '{16'hF000, 16'h1000, 17'h10000};

    bus.in_valid_i  = 1'b0;
    bus.a1_i        = '0;
    bus.a2_i        = '0;
    bus.res_ready_i = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_armed", 64'(armed), 0);
    chk("rst_fault", 64'(fault), 0);
    chk("rst_fcnt", 64'(fcnt), 0);
    chk("rst_key", 64'(bus.keyinput_o), 0);
    chk("rst_ready", 64'(bus.in_ready_o), 0);
    chk("rst_resv", 64'(bus.res_valid_o), 0);
    rst = 1'b0;
    cyc();

    // Good key load
    load_key(32'h93BAF4CF, 1'b0);
    chk("check_armed", 64'(armed), 0);
    chk("check_key", 64'(bus.keyinput_o), 0);
    cyc();
    chk("load_armed", 64'(armed), 1);
    chk("load_key", 64'(bus.keyinput_o), 64'h93BAF4CF);
    chk("load_fcnt", 64'(fcnt), 0);
    chk("load_ready", 64'(bus.in_ready_o), 1);

    // Bad parity from ARMED
    load_key(32'h93BAF4CF, 1'b1);
    cyc();
    chk("bad_fault", 64'(fault), 1);
    chk("bad_armed", 64'(armed), 0);
    chk("bad_key", 64'(bus.keyinput_o), 0);
    chk("bad_fcnt", 64'(fcnt), 1);
    bus.in_valid_i = 1'b1;
    #1;
    chk("bad_ready", 64'(bus.in_ready_o), 0);
    bus.in_valid_i = 1'b0;

    // Saturation: 16 more faults, 17 total
    for (int k = 2; k <= 17; k++) begin
      load_key(32'h93BAF4CF, 1'b1);
      cyc();
      if (k == 14) chk("fcnt_14", 64'(fcnt), 64'hE);
      if (k == 15) chk("fcnt_15", 64'(fcnt), 64'hF);
    end
    chk("fcnt_sat", 64'(fcnt), 64'hF);
    chk("sat_fault", 64'(fault), 1);

    // Recover with a good key
    load_key(32'h93BAF4CF, 1'b0);
    cyc();
    chk("rearm_armed", 64'(armed), 1);
    chk("rearm_key", 64'(bus.keyinput_o), 64'h93BAF4CF);
    chk("rearm_fcnt", 64'(fcnt), 64'hF);

    // Datapath: back-to-back table vectors
    bus.res_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_pair(tbl[i].a1, tbl[i].a2);
      chk($sformatf("dp_ready_%0d", i), 64'(bus.in_ready_o), 1);
      cyc();
      if (i == 0) begin
        chk("dp_latency", 64'(bus.res_valid_o), 0);
      end else begin
        chk($sformatf("dp_resv_%0d", i - 1), 64'(bus.res_valid_o), 1);
        chk($sformatf("dp_res_%0d", i - 1), 64'(bus.res_o), 64'(tbl[i - 1].res));
      end
    end
    bus.in_valid_i = 1'b0;
    cyc();
    chk("dp_resv_5", 64'(bus.res_valid_o), 1);
    chk("dp_res_5", 64'(bus.res_o), 64'(tbl[5].res));
    cyc();
    chk("dp_drained", 64'(bus.res_valid_o), 0);

    // Backpressure: only two pairs fit
    bus.res_ready_i = 1'b0;
    acc_n = 0;
    got_q.delete();
    for (int c = 0; c < 4; c++) begin
      set_pair(bp[acc_n].a1, bp[acc_n].a2);
      cyc();
    end
    chk("bp_accepted", 64'(acc_n), 2);
    chk("bp_ready", 64'(bus.in_ready_o), 0);
    bus.res_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (acc_n < 3) set_pair(bp[acc_n].a1, bp[acc_n].a2);
      else bus.in_valid_i = 1'b0;
      cyc();
    end
    chk("bp_acc_total", 64'(acc_n), 3);
    chk("bp_got_n", 64'(got_q.size()), 3);
    for (int i = 0; i < 3 && i < got_q.size(); i++)
      chk($sformatf("bp_res_%0d", i), 64'(got_q[i]), 64'(bp[i].res));

    // Rekey with two pairs in flight
    bus.res_ready_i = 1'b0;
    acc_n = 0;
    got_q.delete();
    set_pair(16'h00FF, 16'h0001);
    cyc();
    set_pair(16'h7FFF, 16'h7FFF);
    cyc();
    set_pair(16'hAAAA, 16'h5555);
    key_load_start = 1'b1;
    cyc();
    key_load_start = 1'b0;
    chk("rk_ready", 64'(bus.in_ready_o), 0);
    chk("rk_armed", 64'(armed), 1);
    chk("rk_key_held", 64'(bus.keyinput_o), 64'h93BAF4CF);
    bus.res_ready_i = 1'b1;
    n = 0;
    while (armed && n < 10) begin
      cyc();
      n++;
      if (n == 1) chk("rk_ready_pending", 64'(bus.in_ready_o), 0);
    end
    chk("rk_timeout", 64'(n < 10), 1);
    chk("rk_acc", 64'(acc_n), 2);
    chk("rk_got_n", 64'(got_q.size()), 2);
    if (got_q.size() == 2) begin
      chk("rk_res_0", 64'(got_q[0]), 64'h00100);
      chk("rk_res_1", 64'(got_q[1]), 64'h0FFFE);
    end
    chk("rk_load_resv", 64'(bus.res_valid_o), 0);
    chk("rk_load_key", 64'(bus.keyinput_o), 0);
    bus.in_valid_i = 1'b0;

    // Reset mid-LOAD after 10 bits
    for (int i = 0; i < 10; i++) begin
      key_bit = i[0];
      key_bit_valid = 1'b1;
      cyc();
      if (i == 4) chk("load_key_zero", 64'(bus.keyinput_o), 0);
    end
    key_bit_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("mrst_armed", 64'(armed), 0);
    chk("mrst_fault", 64'(fault), 0);
    chk("mrst_fcnt", 64'(fcnt), 0);
    chk("mrst_key", 64'(bus.keyinput_o), 0);
    chk("mrst_add1", 64'(bus.add1_o), 0);
    chk("mrst_add2", 64'(bus.add2_o), 0);
    chk("mrst_res", 64'(bus.res_o), 0);
    chk("mrst_resv", 64'(bus.res_valid_o), 0);
    chk("mrst_ready", 64'(bus.in_ready_o), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();
    load_key(32'h93BAF4CF, 1'b0);
    cyc();
    chk("fresh_armed", 64'(armed), 1);
    chk("fresh_key", 64'(bus.keyinput_o), 64'h93BAF4CF);
    chk("fresh_fcnt", 64'(fcnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

endmodule

// File: doc/eta16_key_operand_feeder.md
Name: eta16_key_operand_feeder

Overview:
Upstream feeder and result-capture stage for the 32-bit-key locked 16-bit error-tolerant type-2 adder (combinational, ports add1_i/add2_i/keyinput/result_o).
- Loads the 32-bit key serially into a shadow register and checks its parity before applying it to the adder's keyinput. A partially loaded or corrupt key never reaches the adder.
- Registers operand pairs into the adder through a valid/ready handshake.
- Captures the adder's 17-bit result one cycle later.

Parameters:
DATA_WIDTH, 16, operand width; the result is DATA_WIDTH+1.
KEY_WIDTH, 32, locking key width.
FCNT_WIDTH, 4, width of the saturating key-fault counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
key_load_start_i  in  1  request a (re)key
key_bit_i  in  1  serial key bit, MSB first, followed by 1 even-parity bit
key_bit_valid_i  in  1  key_bit_i qualifier
in_valid_i  in  1  operand pair valid
in_ready_o  out  1  operand pair accepted when in_valid_i&&in_ready_o
a1_i  in  DATA_WIDTH  operand 1
a2_i  in  DATA_WIDTH  operand 2
add1_o  out  DATA_WIDTH  to adder add1_i
add2_o  out  DATA_WIDTH  to adder add2_i
keyinput_o  out  KEY_WIDTH  to adder keyinput
result_i  in  DATA_WIDTH+1  from adder result_o
res_o  out  DATA_WIDTH+1  captured result
res_valid_o  out  1  res_o valid
res_ready_i  in  1  downstream accepts res_o
armed_o  out  1  key applied
fault_o  out  1  in FAULT state
fault_count_o  out  FCNT_WIDTH  parity failures, saturating

Behaviour:
- Reset (async, any state, including mid-load and mid-stream):
  - state=IDLE.
  - shadow, bit counter, keyinput_o, add1_o, add2_o, res_o, fault_count_o = 0.
  - Stage A valid, res_valid_o, in_ready_o, armed_o, fault_o, rekey-pending = 0.
- FSM states: IDLE, LOAD, CHECK, ARMED, FAULT.
  - IDLE: on key_load_start_i → LOAD; counter=0.
  - LOAD:
    - Each cycle with key_bit_valid_i: shadow<={shadow,key_bit_i} (KEY_WIDTH+1 bits), counter++.
    - After the KEY_WIDTH+1-th valid bit → CHECK.
    - key_load_start_i in LOAD restarts: counter=0; a bit valid in the same cycle is discarded.
  - CHECK (1 cycle):
    - XOR of all KEY_WIDTH+1 bits == 0 → ARMED; keyinput_o<=shadow[KEY_WIDTH:1].
    - Otherwise → FAULT; fault_count_o increments, saturating at all-ones.
  - ARMED:
    - armed_o=1.
    - key_load_start_i sets rekey-pending. While pending, in_ready_o=0.
    - When Stage A and res_valid_o are both empty: → LOAD, pending cleared, keyinput_o<=0.
  - FAULT:
    - fault_o=1, keyinput_o=0.
    - key_load_start_i → LOAD. No other exit.
- keyinput_o is nonzero only in ARMED. It changes only on the CHECK→ARMED edge or when leaving ARMED.
- Pipeline:
  - Stage A drives add1_o/add2_o. Stage B is res_o/res_valid_o.
  - advB = A_valid && (!res_valid_o || res_ready_i).
  - in_ready_o = armed_o && !pending && (!A_valid || advB). This is combinational.
  - On accept: add1_o<=a1_i, add2_o<=a2_i, A_valid<=1.
  - On advB: res_o<=result_i, res_valid_o<=1. If A is not refilled in the same cycle, A_valid<=0.
  - res_valid_o clears on res_ready_i when not refilled.
  - add1_o/add2_o hold their value when Stage A is empty.
- Latency and throughput:
  - A pair accepted at edge N gives res_valid_o after edge N+1.
  - Throughput is 1 pair/cycle with res_ready_i=1.
  - Capacity is 2 pairs in flight. Order is preserved and nothing is dropped.
- Result width: result_i is captured unmodified (17 bits); no arithmetic is done here.
- Simultaneous events:
  - Accept and advB in the same cycle are both performed.
  - res_ready_i and advB in the same cycle: res_o is replaced and res_valid_o stays 1.
  - key_load_start_i in the same cycle as an accept: the accept completes and pending is set.

Test Plan:
- Key load: key_bit_i streams 32'h93BAF4CF MSB first, then parity bit 0 → CHECK one cycle later, then armed_o=1, keyinput_o=32'h93BAF4CF, fault_count_o=0.
- Bad parity: same key with parity bit 1 → fault_o=1, keyinput_o=0, fault_count_o=1, in_ready_o=0. A 16-fault loop saturates fault_count_o at 4'hF.
- Datapath: armed, with a stub result_i=add1_o+add2_o; offer a1=16'h29AF, a2=16'h7A1B at edge N → res_o=17'h0A3CA, res_valid_o=1 after N+1. Back-to-back pairs 1100/1111 and 8943/FFFF give 02211 and 18942 on consecutive cycles.
- Backpressure: res_ready_i=0, 3 pairs offered → 2 accepted, in_ready_o=0. Release → results drain in order with no loss or duplication.
- Rekey mid-stream: key_load_start_i while 2 pairs are in flight → in_ready_o=0. LOAD is entered only after both results drain, and keyinput_o=0 during LOAD.
- Reset mid-LOAD after 10 bits → all outputs 0, IDLE. A fresh full load then succeeds.
